// File: rtl/alu_exec_unit.sv
// Sequencer around an external combinational ALU: 4x8 register file, flags register,
// IDLE -> EXEC -> RESP handshake with a side-band register load and debug read port.
module alu_exec_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [1:0] req_src_a,
   input  logic [1:0] req_src_b,
   input  logic [1:0] req_dst,
   input  logic       req_imm_en,
   input  logic [7:0] req_imm,
   input  logic       req_wb_en,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic [7:0] alu_cpu_flags,
   input  logic [7:0] alu_c,
   input  logic [7:0] alu_flags,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] resp_data,
   output logic [7:0] resp_flags,
   input  logic       ld_en,
   input  logic [1:0] ld_sel,
   input  logic [7:0] ld_data,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic [1:0]      dst_q, dst_d;
   logic            wb_en_q, wb_en_d;
   logic [7:0]      a_q, a_d;
   logic [7:0]      b_q, b_d;
   logic [7:0]      result_q, result_d;
   logic [7:0]      fr_q, fr_d;
   logic [3:0][7:0] rf_q, rf_d;
   logic            req_ready_q, req_ready_d;
   logic            resp_valid_q, resp_valid_d;

   // Next-state, operand capture, result capture and register-file update
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      dst_d        = dst_q;
      wb_en_d      = wb_en_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      fr_d         = fr_q;
      rf_d         = rf_q;
      resp_valid_d = resp_valid_q;

      if (ld_en) begin
         rf_d[ld_sel] = ld_data;
      end else begin
         rf_d = rf_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_EXEC;
               op_d    = req_op;
               dst_d   = req_dst;
               wb_en_d = req_wb_en;
               a_d     = rf_q[req_src_a];
               b_d     = req_imm_en ? req_imm : rf_q[req_src_b];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d      = ST_RESP;
            result_d     = alu_c;
            fr_d         = alu_flags & 8'h3F;
            resp_valid_d = 1'b1;
            // Writeback is applied after the load port so it wins on a collision
            if (wb_en_q) begin
               rf_d[dst_q] = alu_c;
            end else begin
               rf_d[dst_q] = rf_d[dst_q];
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
            end else begin
               state_d      = ST_RESP;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= 4'd0;
         dst_q        <= 2'd0;
         wb_en_q      <= 1'b0;
         a_q          <= 8'd0;
         b_q          <= 8'd0;
         result_q     <= 8'd0;
         fr_q         <= 8'd0;
         rf_q         <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         dst_q        <= dst_d;
         wb_en_q      <= wb_en_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         fr_q         <= fr_d;
         rf_q         <= rf_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // ALU drive is gated to EXEC so the ALU sees zeros otherwise
   always_comb begin
      if (state_q == ST_EXEC) begin
         alu_a  = a_q;
         alu_b  = b_q;
         alu_op = op_q;
      end else begin
         alu_a  = 8'd0;
         alu_b  = 8'd0;
         alu_op = 4'd0;
      end
   end

   assign alu_cpu_flags = fr_q;
   assign req_ready     = req_ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = result_q;
   assign resp_flags    = fr_q;
   assign dbg_data      = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: behavioural ALU on the ALU port, directed vector
// table, hand-written corner sequences and randomized transactions against a reference model.
module tb_alu_exec_unit;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_ADC = 4'd5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready;
   logic [3:0] req_op;
   logic [1:0] req_src_a, req_src_b, req_dst;
   logic       req_imm_en, req_wb_en;
   logic [7:0] req_imm;
   logic [7:0] alu_a, alu_b, alu_cpu_flags, alu_c, alu_flags;
   logic [3:0] alu_op;
   logic       resp_valid, resp_ready;
   logic [7:0] resp_data, resp_flags;
   logic       ld_en;
   logic [1:0] ld_sel, dbg_sel;
   logic [7:0] ld_data, dbg_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_rf [4];
   logic [7:0] m_fr;

   alu_exec_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
      .req_imm_en(req_imm_en), .req_imm(req_imm), .req_wb_en(req_wb_en),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cpu_flags(alu_cpu_flags),
      .alu_c(alu_c), .alu_flags(alu_flags),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_flags(resp_flags),
      .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {flags, result}; flags[7:6] are deliberately set to 1
   function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
      int s;
      logic [7:0] c;
      logic cy, ac, ov;
      s = 0; cy = 1'b0; ac = 1'b0; ov = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            s  = int'(a) + int'(b) + ((op == OP_ADC) ? int'(cin) : 0);
            c  = s[7:0];
            cy = (s > 255);
            ac = (int'(a % 16) + int'(b % 16) + ((op == OP_ADC) ? int'(cin) : 0)) > 15;
            ov = (a[7] == b[7]) && (c[7] != a[7]);
         end
         OP_SUB: begin
            s  = int'(a) - int'(b);
            c  = s[7:0];
            cy = (a < b);
            ac = (a % 16) < (b % 16);
            ov = (a[7] != b[7]) && (c[7] != a[7]);
         end
         OP_AND:  c = a & b;
         OP_OR:   c = a | b;
         OP_XOR:  c = a ^ b;
         default: c = a;
      endcase
      return {2'b11, ov, ~^c, c[7], (c == 8'd0), ac, cy, c};
   endfunction

   always_comb {alu_flags, alu_c} = ref_alu(alu_op, alu_a, alu_b, alu_cpu_flags[0]);

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_regs(input string name);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         chk($sformatf("%s r%0d", name, i), dbg_data, m_rf[i]);
      end
   endtask

   task automatic load(input logic [1:0] sel, input logic [7:0] data);
      @(negedge clk);
      ld_en = 1'b1; ld_sel = sel; ld_data = data;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
      m_rf[sel] = data;
   endtask

   // One transaction: accept, EXEC, RESP held 'hold' cycles, back to IDLE
   task automatic do_op(input string name, input logic [3:0] op, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [1:0] dst, input logic ie,
                        input logic [7:0] imm, input logic wb, input int hold,
                        input logic xld, input logic [1:0] xsel, input logic [7:0] xdata,
                        input logic [7:0] exp_data, input logic [7:0] exp_flags);
      logic [7:0] ea, eb;
      ea = m_rf[sa];
      eb = ie ? imm : m_rf[sb];
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_src_a = sa; req_src_b = sb; req_dst = dst;
      req_imm_en = ie; req_imm = imm; req_wb_en = wb; resp_ready = (hold == 0);
      chk({name, " ready_idle"}, {7'd0, req_ready}, 8'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk({name, " alu_a"}, alu_a, ea);
      chk({name, " alu_b"}, alu_b, eb);
      chk({name, " alu_op"}, {4'd0, alu_op}, {4'd0, op});
      chk({name, " cpu_flags"}, alu_cpu_flags, m_fr);
      chk({name, " exec_ready"}, {6'd0, req_ready, resp_valid}, 8'd0);
      ld_en = xld; ld_sel = xsel; ld_data = xdata;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
      if (xld) m_rf[xsel] = xdata;
      if (wb) m_rf[dst] = exp_data;
      m_fr = exp_flags;
      chk({name, " resp_valid"}, {7'd0, resp_valid}, 8'd1);
      chk({name, " resp_data"}, resp_data, exp_data);
      chk({name, " resp_flags"}, resp_flags, exp_flags);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_op = 4'($urandom); req_src_a = 2'($urandom);
         req_src_b = 2'($urandom); req_dst = 2'($urandom); req_wb_en = 1'b1;
         req_imm_en = 1'($urandom); req_imm = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk({name, " hold_valid"}, {6'd0, req_ready, resp_valid}, 8'd1);
         chk({name, " hold_data"}, resp_data, exp_data);
         chk({name, " hold_flags"}, resp_flags, exp_flags);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({name, " back_idle"}, {6'd0, req_ready, resp_valid}, 8'd2);
      chk({name, " idle_alu_a"}, alu_a, 8'd0);
      chk_regs(name);
   endtask

   typedef struct {
      logic [3:0] op;
      logic [1:0] sa, sb, dst;
      logic       ie;
      logic [7:0] imm;
      logic       wb;
      logic [7:0] exp_data, exp_flags;
   } vec_t;

   vec_t tbl[4];

   initial begin
      logic [3:0]  op;
      logic [1:0]  sa, sb, dst, xs;
      logic        ie, wb, xl;
      logic [7:0]  imm, xd, a, b;
      logic [15:0] r;

      tbl[0] = '{OP_AND, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1, 8'h8A, 8'h08};
      tbl[1] = '{OP_ADD, 2'd0, 2'd0, 2'd3, 1'b1, 8'hAA, 1'b1, 8'h74, 8'h33};
      tbl[2] = '{OP_ADC, 2'd2, 2'd3, 2'd0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h18};
      tbl[3] = '{OP_ADD, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00, 1'b1, 8'h14, 8'h33};

      rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_src_a = 2'd0; req_src_b = 2'd0;
      req_dst = 2'd0; req_imm_en = 1'b0; req_imm = 8'd0; req_wb_en = 1'b0;
      resp_ready = 1'b1; ld_en = 1'b0; ld_sel = 2'd0; ld_data = 8'd0; dbg_sel = 2'd0;
      for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
      m_fr = 8'd0;

      #12;
      chk("reset ready", {7'd0, req_ready}, 8'd1);
      chk("reset resp_valid", {7'd0, resp_valid}, 8'd0);
      chk("reset alu_a", alu_a, 8'd0);
      chk("reset alu_op", {4'd0, alu_op}, 8'd0);
      chk("reset resp_data", resp_data, 8'd0);
      chk("reset resp_flags", resp_flags, 8'd0);
      chk("reset cpu_flags", alu_cpu_flags, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release ready", {7'd0, req_ready}, 8'd1);
      chk_regs("reset");

      load(2'd0, 8'hCA);
      load(2'd1, 8'hAA);
      for (int i = 0; i < 4; i++)
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sa, tbl[i].sb, tbl[i].dst,
               tbl[i].ie, tbl[i].imm, tbl[i].wb, 0, 1'b0, 2'd0, 8'd0,
               tbl[i].exp_data, tbl[i].exp_flags);

      // Load/writeback collision, then load of a source register during EXEC
      load(2'd0, 8'hCA);
      load(2'd1, 8'hAA);
      do_op("collide", OP_AND, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1, 0,
            1'b1, 2'd2, 8'h55, 8'h8A, 8'h08);
      do_op("ld_src", OP_OR, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00, 1'b1, 0,
            1'b1, 2'd1, 8'h0F, 8'hEA, 8'h08);

      // No writeback, zero result
      load(2'd0, 8'h10);
      load(2'd1, 8'h10);
      do_op("sub_nowb", OP_SUB, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 0,
            1'b0, 2'd0, 8'd0, 8'h00, 8'h14);

      // Back-pressure for five cycles
      do_op("hold5", OP_XOR, 2'd0, 2'd0, 2'd3, 1'b1, 8'h3C, 1'b1, 5,
            1'b0, 2'd0, 8'd0, 8'h2C, 8'h00);

      // Reset pulsed during EXEC aborts the operation
      load(2'd1, 8'h77);
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_ADD; req_src_a = 2'd0; req_src_b = 2'd0;
      req_dst = 2'd1; req_imm_en = 1'b1; req_imm = 8'hF5; req_wb_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort alu_a", alu_a, 8'd0);
      chk("abort ready", {7'd0, req_ready}, 8'd1);
      for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
      m_fr = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort quiet", {6'd0, req_ready, resp_valid}, 8'd2);
         chk("abort fr", alu_cpu_flags, 8'd0);
      end
      chk_regs("abort");

      // Randomized transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) load(2'($urandom), 8'($urandom));
         op  = 4'($urandom_range(0, 6));
         sa  = 2'($urandom); sb = 2'($urandom); dst = 2'($urandom);
         ie  = 1'($urandom); imm = 8'($urandom); wb = ($urandom_range(0, 3) != 0);
         xl  = ($urandom_range(0, 3) == 0); xs = 2'($urandom); xd = 8'($urandom);
         a   = m_rf[sa];
         b   = ie ? imm : m_rf[sb];
         r   = ref_alu(op, a, b, m_fr[0]);
         do_op($sformatf("rnd%0d", n), op, sa, sb, dst, ie, imm, wb,
               int'($urandom_range(0, 2)), xl, xs, xd, r[7:0], r[15:8] & 8'h3F);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk input 1, all state rising-edge; rst_n input 1, async assert, sync release.
REQ-002 SHALL have: req_valid in 1, request present; req_ready out 1, unit idle and accepting.
REQ-003 SHALL have: req_op in 4, opcode passed unmodified to ALU; req_src_a in 2, req_src_b in 2, req_dst in 2, register indices.
REQ-004 SHALL have: req_imm_en in 1, B operand from req_imm; req_imm in 8; req_wb_en in 1, write result to req_dst.
REQ-005 SHALL have: alu_a out 8, alu_b out 8, alu_op out 4, alu_cpu_flags out 8, to the combinational ALU; alu_c in 8, alu_flags in 8, from ALU.
REQ-006 SHALL have: resp_valid out 1, resp_ready in 1, resp_data out 8 result, resp_flags out 8 flags.
REQ-007 SHALL have: ld_en in 1, ld_sel in 2, ld_data in 8, register load port; dbg_sel in 2, dbg_data out 8, combinational register read.

Function
REQ-008 SHALL hold a 4x8 register file r0..r3 and an 8-bit flags register FR; FR[5:0] = overflow, parity, sign, zero, aux_carry, carry; FR[7:6] always 0.
REQ-009 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-010 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-011 On accept SHALL latch op, dst, wb_en, A = r[src_a], B = (imm_en ? imm : r[src_b]) using register values before that edge, and go to EXEC.
REQ-012 In EXEC SHALL drive alu_a=A, alu_b=B, alu_op=op; in IDLE and RESP SHALL drive alu_a=alu_b=0, alu_op=0.
REQ-013 SHALL drive alu_cpu_flags = FR in all states.
REQ-014 At the EXEC-ending edge SHALL capture alu_c into result register, FR <= alu_flags & 8'h3F, r[dst] <= alu_c if wb_en, and go to RESP.
REQ-015 In RESP SHALL assert resp_valid, resp_data = captured result, resp_flags = FR, all stable until resp_ready; edge with resp_ready=1 returns to IDLE.
REQ-016 Latency: resp_valid SHALL rise after the 2nd rising edge following accept; with resp_ready tied 1, next accept possible 3 edges after previous accept.
REQ-017 ld_en=1 SHALL write ld_data to r[ld_sel] in any state; same edge and same register as EXEC writeback -> writeback wins.
REQ-018 ld to a source register during EXEC SHALL NOT affect the in-flight operation (operands already latched).
REQ-019 src_a = src_b = dst SHALL be legal; result overwrites after operands read.
REQ-020 req_valid while not IDLE SHALL be ignored, no side effects; requester holds it.
REQ-021 dbg_data SHALL equal r[dbg_sel] combinationally, reflecting writes from the previous edge.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, r0..r3=0, FR=0, result=0, resp_valid=0, alu_* outputs 0, resp_data=resp_flags=0.
REQ-023 rst_n=0 during EXEC or RESP SHALL abort: no writeback, no FR update, no response after release.
REQ-024 req_ready SHALL be 1 during reset and on the first edge after release.

Verification
REQ-025 Load r0=0xCA, r1=0xAA; OP_AND src_a=0 src_b=1 dst=2 wb_en=1 -> resp_data=0x8A, r2=0x8A, resp_valid exactly 2 edges after accept.
REQ-026 r0=0xCA, imm_en=1 imm=0xAA, OP_ADD dst=3 -> resp_data=0x74, FR carry=1, overflow=1; next op sees alu_cpu_flags=FR.
REQ-027 resp_ready held 0 for 5 cycles -> resp_valid, resp_data, resp_flags stable; req_valid pulses ignored, req_ready=0; release -> IDLE next edge.
REQ-028 ld_en to r2 with 0x55 on same edge as EXEC writeback to r2 of 0x8A -> r2=0x8A; ld to r1 during EXEC of op reading r1 -> result uses old r1.
REQ-029 rst_n pulsed low during EXEC -> dst unchanged (0), FR=0, resp_valid never asserts, req_ready=1.
REQ-030 wb_en=0 OP_SUB r0=r1=0x10 -> resp_data=0x00, FR zero=1, r0..r3 unchanged.
